// File: rtl/reg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// reg_ctrl_pkg
// Shared definitions for the register-transfer controller: default geometry,
// command op codes, controller FSM state encoding and the command legality
// check used at accept time.
// -----------------------------------------------------------------------------
package reg_ctrl_pkg;

  localparam int N_REGS_DEF = 4;
  localparam int IDX_W_DEF  = 2;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_LDI = 2'b01,
    OP_RD  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // A command is legal when its op is defined and every register index it
  // actually uses lies inside the bank. Unused index fields are don't-care.
  function automatic logic cmd_is_legal(input logic [1:0] op,
                                        input int         src,
                                        input int         dst,
                                        input int         n_regs);
    logic ok;
    case (op)
      OP_MOV:  ok = (src < n_regs) && (dst < n_regs);
      OP_LDI:  ok = (dst < n_regs);
      OP_RD:   ok = (src < n_regs);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/reg_transfer_controller_if.sv
// -----------------------------------------------------------------------------
// reg_transfer_controller_if
// One requester's command channel into the register-transfer controller.
//   valid : requester has a command (held until ready)
//   op    : 00 MOV, 01 LDI, 10 RD, 11 reserved
//   src   : source register index
//   dst   : destination register index
//   imm   : immediate value for LDI
//   ready : command accepted this cycle (driven by the controller)
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface reg_transfer_controller_if #(
  parameter int IDX_W  = reg_ctrl_pkg::IDX_W_DEF,
  parameter int DATA_W = reg_ctrl_pkg::DATA_W_DEF
);

  logic              valid;
  logic [1:0]        op;
  logic [IDX_W-1:0]  src;
  logic [IDX_W-1:0]  dst;
  logic [DATA_W-1:0] imm;
  logic              ready;

  modport master (output valid, output op, output src, output dst, output imm,
                  input  ready);

  modport slave  (input  valid, input  op, input  src, input  dst, input  imm,
                  output ready);

endinterface

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. When both requesters are valid the one that was
// not granted last wins; a single valid requester always wins. Grants are only
// issued while enable is high, and last_grant only moves on an actual grant.
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-low reset (last_grant=1 -> req 0 first)
//   valid0/1  : request lines
//   enable    : controller is able to accept a command
//   grant     : one-hot grant, bit i for requester i
//   grant_id  : index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic       last_grant_r;
  logic [1:0] grant_s;
  logic       grant_id_s;

  // Grant selection, fair between two simultaneous requests.
  always_comb begin
    grant_s    = 2'b00;
    grant_id_s = 1'b0;
    if (enable) begin
      if (valid0 && valid1) begin
        grant_id_s = ~last_grant_r;
        grant_s    = last_grant_r ? 2'b01 : 2'b10;
      end else if (valid0) begin
        grant_id_s = 1'b0;
        grant_s    = 2'b01;
      end else if (valid1) begin
        grant_id_s = 1'b1;
        grant_s    = 2'b10;
      end else begin
        grant_id_s = 1'b0;
        grant_s    = 2'b00;
      end
    end else begin
      grant_id_s = 1'b0;
      grant_s    = 2'b00;
    end
  end

  // Remember the most recent winner for the next tie-break.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_r <= 1'b1;
    end else if (|grant_s) begin
      last_grant_r <= grant_id_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign grant    = grant_s;
  assign grant_id = grant_id_s;

endmodule

// File: rtl/reg_transfer_controller.sv
// -----------------------------------------------------------------------------
// reg_transfer_controller
// Sequences the shared data bus of the general-purpose register bank. Two
// requesters (0: control unit, 1: I/O/debug port) issue MOV / LDI / RD
// commands; one command runs at a time, arbitrated round-robin.
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-low reset (aborts any command in flight)
//   req0, req1  : command channels (slave modport), ready is combinational
//   reg_values  : concatenated register outputs, reg i at [i*DATA_W +: DATA_W]
//   read_en     : one-hot read strobe (READ state only)
//   write_en    : one-hot write strobe (WRITE state only)
//   data_bus    : value driven to the registers, 0 outside WRITE
//   done        : one-cycle completion pulse
//   rsp_id      : requester of the completed command
//   rsp_data    : value read (RD) or transferred (MOV/LDI); 0 for rejects
//   rsp_err     : command rejected (reserved op or index out of range)
// Timing from accept (cycle 0) to done: MOV 4, RD 3, LDI 2, reject 1.
// All outputs except ready are registers loaded from the next-state values,
// so each strobe lines up with the cycle its state is occupied.
// -----------------------------------------------------------------------------
module reg_transfer_controller
  import reg_ctrl_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  reg_transfer_controller_if.slave   req0,
  reg_transfer_controller_if.slave   req1,
  input  logic [N_REGS*DATA_W-1:0]   reg_values,
  output logic [N_REGS-1:0]          read_en,
  output logic [N_REGS-1:0]          write_en,
  output logic [DATA_W-1:0]          data_bus,
  output logic                       done,
  output logic                       rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err
);

  state_e              state_r;
  state_e              state_nxt_s;

  logic [1:0]          op_r,     op_nxt_s;
  logic [IDX_W-1:0]    src_r,    src_nxt_s;
  logic [IDX_W-1:0]    dst_r,    dst_nxt_s;
  logic [DATA_W-1:0]   data_q_r, data_q_nxt_s;
  logic                id_r,     id_nxt_s;
  logic                err_r,    err_nxt_s;

  logic [1:0]          grant_s;
  logic                grant_id_s;
  logic                arb_en_s;

  logic [1:0]          sel_op_s;
  logic [IDX_W-1:0]    sel_src_s;
  logic [IDX_W-1:0]    sel_dst_s;
  logic [DATA_W-1:0]   sel_imm_s;

  logic [N_REGS-1:0]   rd_dec_s;
  logic [N_REGS-1:0]   wr_dec_s;
  logic [DATA_W-1:0]   rd_mux_s;

  logic [N_REGS-1:0]   read_en_r;
  logic [N_REGS-1:0]   write_en_r;
  logic [DATA_W-1:0]   data_bus_r;
  logic                done_r;
  logic                rsp_id_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_err_r;

  assign arb_en_s = (state_r == ST_IDLE);

  rr_arbiter2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .valid0   (req0.valid),
    .valid1   (req1.valid),
    .enable   (arb_en_s),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  // Grants only exist in IDLE, so ready is low everywhere else.
  assign req0.ready = grant_s[0];
  assign req1.ready = grant_s[1];

  // Payload of the granted requester.
  always_comb begin
    if (grant_id_s) begin
      sel_op_s  = req1.op;
      sel_src_s = req1.src;
      sel_dst_s = req1.dst;
      sel_imm_s = req1.imm;
    end else begin
      sel_op_s  = req0.op;
      sel_src_s = req0.src;
      sel_dst_s = req0.dst;
      sel_imm_s = req0.imm;
    end
  end

  // Read mux: value of the latched source register.
  always_comb begin
    rd_mux_s = '0;
    for (int i = 0; i < N_REGS; i++) begin
      rd_mux_s = (int'(src_r) == i) ? reg_values[i*DATA_W +: DATA_W] : rd_mux_s;
    end
  end

  // Next-state and command-latch logic.
  always_comb begin
    state_nxt_s  = state_r;
    op_nxt_s     = op_r;
    src_nxt_s    = src_r;
    dst_nxt_s    = dst_r;
    data_q_nxt_s = data_q_r;
    id_nxt_s     = id_r;
    err_nxt_s    = err_r;
    case (state_r)
      ST_IDLE: begin
        if (|grant_s) begin
          op_nxt_s  = sel_op_s;
          src_nxt_s = sel_src_s;
          dst_nxt_s = sel_dst_s;
          id_nxt_s  = grant_id_s;
          if (!cmd_is_legal(sel_op_s, int'(sel_src_s), int'(sel_dst_s), N_REGS)) begin
            // Rejected commands report a zero value rather than stale data.
            state_nxt_s  = ST_DONE;
            err_nxt_s    = 1'b1;
            data_q_nxt_s = '0;
          end else begin
            err_nxt_s = 1'b0;
            case (sel_op_s)
              OP_LDI: begin
                state_nxt_s  = ST_WRITE;
                data_q_nxt_s = sel_imm_s;
              end
              OP_MOV, OP_RD: begin
                state_nxt_s = ST_READ;
              end
              default: begin
                state_nxt_s  = ST_DONE;
                err_nxt_s    = 1'b1;
                data_q_nxt_s = '0;
              end
            endcase
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        // The register presents its value one cycle after read_en.
        data_q_nxt_s = rd_mux_s;
        if (op_r == OP_MOV) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_WRITE: begin
        state_nxt_s = ST_DONE;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Index decoders for the strobes of the upcoming state.
  always_comb begin
    rd_dec_s = '0;
    wr_dec_s = '0;
    for (int i = 0; i < N_REGS; i++) begin
      rd_dec_s[i] = (int'(src_nxt_s) == i);
      wr_dec_s[i] = (int'(dst_nxt_s) == i);
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latched command fields and transfer data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_r     <= 2'b00;
      src_r    <= '0;
      dst_r    <= '0;
      data_q_r <= '0;
      id_r     <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      op_r     <= op_nxt_s;
      src_r    <= src_nxt_s;
      dst_r    <= dst_nxt_s;
      data_q_r <= data_q_nxt_s;
      id_r     <= id_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  // Output registers: strobes follow the state being entered, response
  // fields load on entry to DONE and hold otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_en_r  <= '0;
      write_en_r <= '0;
      data_bus_r <= '0;
      done_r     <= 1'b0;
      rsp_id_r   <= 1'b0;
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
    end else begin
      read_en_r  <= (state_nxt_s == ST_READ)  ? rd_dec_s     : '0;
      write_en_r <= (state_nxt_s == ST_WRITE) ? wr_dec_s     : '0;
      data_bus_r <= (state_nxt_s == ST_WRITE) ? data_q_nxt_s : '0;
      done_r     <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_DONE) begin
        rsp_id_r   <= id_nxt_s;
        rsp_data_r <= data_q_nxt_s;
        rsp_err_r  <= err_nxt_s;
      end else begin
        rsp_id_r   <= rsp_id_r;
        rsp_data_r <= rsp_data_r;
        rsp_err_r  <= rsp_err_r;
      end
    end
  end

  assign read_en  = read_en_r;
  assign write_en = write_en_r;
  assign data_bus = data_bus_r;
  assign done     = done_r;
  assign rsp_id   = rsp_id_r;
  assign rsp_data = rsp_data_r;
  assign rsp_err  = rsp_err_r;

endmodule

// File: tb/tb_reg_transfer_controller.sv
// -----------------------------------------------------------------------------
// tb_reg_transfer_controller
// Transaction-level model of the controller: each accepted command is turned
// into a timeline of expected strobes, bus values and responses keyed by cycle
// number, and every cycle the DUT outputs are compared against that timeline.
// A small register bank driven by write_en/data_bus feeds reg_values.
// -----------------------------------------------------------------------------
module tb_reg_transfer_controller;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [7:0] imm;
  } cmd_t;

  typedef struct packed {
    logic       rdy1;
    logic       rdy0;
    logic       err;
    logic       id;
    logic [7:0] data;
    logic       done;
    logic [7:0] bus;
    logic [3:0] wr;
    logic [3:0] rd;
  } obs_t;

  localparam int NR = 4;

  logic        clock;
  logic        reset;
  logic [31:0] reg_values;
  logic [3:0]  read_en;
  logic [3:0]  write_en;
  logic [7:0]  data_bus;
  logic        done;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;

  reg_transfer_controller_if r0_if ();
  reg_transfer_controller_if r1_if ();

  reg_transfer_controller dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (r0_if),
    .req1       (r1_if),
    .reg_values (reg_values),
    .read_en    (read_en),
    .write_en   (write_en),
    .data_bus   (data_bus),
    .done       (done),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Environment register bank.
  logic [7:0] bank [0:3] = '{8'hFF, 8'h3C, 8'h00, 8'h00};
  always @(posedge clock) begin
    for (int i = 0; i < NR; i++) begin
      if (write_en[i]) bank[i] <= data_bus;
    end
  end
  assign reg_values = {bank[3], bank[2], bank[1], bank[0]};

  // Model state.
  logic [7:0] mdl [0:3] = '{8'hFF, 8'h3C, 8'h00, 8'h00};
  logic [3:0] sch_rd   [int];
  logic [3:0] sch_wr   [int];
  logic [7:0] sch_bus  [int];
  int         sch_widx [int];
  logic [9:0] sch_done [int];
  obs_t       obs      [int];
  logic [9:0] hold;
  logic       last_g;
  int         free_at;
  logic [1:0] acc_now;
  int         acc_cnt [2];
  int         acc_cyc [2];

  int n_cmp = 0;
  int n_bad = 0;

  cmd_t q0 [$];
  cmd_t q1 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic obs_t get_obs(input int c);
    obs_t o;
    o = 'x;
    if (obs.exists(c)) o = obs[c];
    return o;
  endfunction

  // Expand one accepted command into its expected timeline.
  task automatic schedule(input cmd_t c, input int t, input logic id);
    logic       err;
    logic [7:0] v;
    logic [3:0] one;
    one = 4'b0001;
    err = (c.op == 2'b11) ||
          ((c.op != 2'b01) && (int'(c.src) >= NR)) ||
          ((c.op != 2'b10) && (int'(c.dst) >= NR));
    if (err) begin
      sch_done[t+1] = {1'b1, id, 8'h00};
      free_at = t + 2;
    end else if (c.op == 2'b01) begin
      sch_wr[t+1] = one << c.dst;  sch_bus[t+1] = c.imm;  sch_widx[t+1] = int'(c.dst);
      sch_done[t+2] = {1'b0, id, c.imm};
      free_at = t + 3;
    end else if (c.op == 2'b00) begin
      v = mdl[c.src];
      sch_rd[t+1] = one << c.src;
      sch_wr[t+3] = one << c.dst;  sch_bus[t+3] = v;  sch_widx[t+3] = int'(c.dst);
      sch_done[t+4] = {1'b0, id, v};
      free_at = t + 5;
    end else begin
      v = mdl[c.src];
      sch_rd[t+1] = one << c.src;
      sch_done[t+3] = {1'b0, id, v};
      free_at = t + 4;
    end
  endtask

  // Model + per-cycle compare, sampled on the falling edge.
  initial begin
    logic v0, v1, g, e_done;
    logic [3:0] e_rd, e_wr;
    logic [7:0] e_bus;
    logic [1:0] e_rdy;
    cmd_t c;
    hold = '0; last_g = 1'b1; free_at = 0; acc_now = 2'b00;
    acc_cnt[0] = 0; acc_cnt[1] = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        sch_rd.delete(); sch_wr.delete(); sch_bus.delete();
        sch_widx.delete(); sch_done.delete();
        hold = '0; last_g = 1'b1; free_at = 0; acc_now = 2'b00;
      end else begin
        acc_now = 2'b00;
        e_rdy = 2'b00;
        v0 = r0_if.valid;
        v1 = r1_if.valid;
        if (cyc >= free_at && (v0 || v1)) begin
          if (v0 && v1) g = ~last_g;
          else          g = v0 ? 1'b0 : 1'b1;
          last_g = g;
          acc_now[g] = 1'b1;
          e_rdy[g] = 1'b1;
          acc_cyc[g] = cyc;
          acc_cnt[g]++;
          if (g) c = {r1_if.op, r1_if.src, r1_if.dst, r1_if.imm};
          else   c = {r0_if.op, r0_if.src, r0_if.dst, r0_if.imm};
          schedule(c, cyc, g);
        end
        e_rd  = sch_rd.exists(cyc)  ? sch_rd[cyc]  : 4'h0;
        e_wr  = sch_wr.exists(cyc)  ? sch_wr[cyc]  : 4'h0;
        e_bus = sch_bus.exists(cyc) ? sch_bus[cyc] : 8'h00;
        e_done = 1'b0;
        if (sch_widx.exists(cyc)) mdl[sch_widx[cyc]] = sch_bus[cyc];
        if (sch_done.exists(cyc)) begin
          hold = sch_done[cyc];
          e_done = 1'b1;
        end
        obs[cyc] = {r1_if.ready, r0_if.ready, rsp_err, rsp_id, rsp_data,
                    done, data_bus, write_en, read_en};
        chk("read_en",  read_en,  e_rd);
        chk("write_en", write_en, e_wr);
        chk("data_bus", data_bus, e_bus);
        chk("done",     done,     e_done);
        chk("rsp_err",  rsp_err,  hold[9]);
        chk("rsp_id",   rsp_id,   hold[8]);
        chk("rsp_data", rsp_data, hold[7:0]);
        chk("req0_ready", r0_if.ready, e_rdy[0]);
        chk("req1_ready", r1_if.ready, e_rdy[1]);
      end
    end
  end

  // Requester drivers: hold a command until accepted, then load the next.
  initial begin
    cmd_t c;
    r0_if.valid = 1'b0; r0_if.op = 2'b00; r0_if.src = 2'b00; r0_if.dst = 2'b00; r0_if.imm = 8'h00;
    r1_if.valid = 1'b0; r1_if.op = 2'b00; r1_if.src = 2'b00; r1_if.dst = 2'b00; r1_if.imm = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      if (acc_now[0]) r0_if.valid = 1'b0;
      if (acc_now[1]) r1_if.valid = 1'b0;
      if (!r0_if.valid && q0.size() > 0) begin
        c = q0.pop_front();
        r0_if.valid = 1'b1; r0_if.op = c.op; r0_if.src = c.src; r0_if.dst = c.dst; r0_if.imm = c.imm;
      end
      if (!r1_if.valid && q1.size() > 0) begin
        c = q1.pop_front();
        r1_if.valid = 1'b1; r1_if.op = c.op; r1_if.src = c.src; r1_if.dst = c.dst; r1_if.imm = c.imm;
      end
    end
  end

  task automatic wait_acc(input int k, input int prev, input int budget);
    int n;
    n = 0;
    while (acc_cnt[k] == prev && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (acc_cnt[k] == prev) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout req%0d after %0d cycles", k, budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    int a, a0, a1, p0, p1, n;
    obs_t o;
    cmd_t c;

    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_read_en",  read_en,  32'h0);
    chk("rst_write_en", write_en, 32'h0);
    chk("rst_data_bus", data_bus, 32'h0);
    chk("rst_done",     done,     32'h0);
    chk("rst_rsp_id",   rsp_id,   32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err",  rsp_err,  32'h0);
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock);

    // LDI dst=2 imm=A5 from requester 0.
    p0 = acc_cnt[0];
    q0.push_back({2'b01, 2'd0, 2'd2, 8'hA5});
    wait_acc(0, p0, 20);
    repeat (6) @(posedge clock);
    a = acc_cyc[0];
    o = get_obs(a);     chk("t1_ready0", o.rdy0, 32'h1);
    o = get_obs(a + 1); chk("t1_wr", o.wr, 32'h4); chk("t1_bus", o.bus, 32'hA5);
    o = get_obs(a + 2); chk("t1_done", o.done, 32'h1); chk("t1_data", o.data, 32'hA5);
    chk("t1_id", o.id, 32'h0); chk("t1_err", o.err, 32'h0);

    // MOV R1 -> R3 from requester 1.
    p1 = acc_cnt[1];
    q1.push_back({2'b00, 2'd1, 2'd3, 8'h00});
    wait_acc(1, p1, 20);
    repeat (6) @(posedge clock);
    a = acc_cyc[1];
    o = get_obs(a + 1); chk("t2_rd", o.rd, 32'h2);
    o = get_obs(a + 3); chk("t2_wr", o.wr, 32'h8); chk("t2_bus", o.bus, 32'h3C);
    o = get_obs(a + 4); chk("t2_done", o.done, 32'h1); chk("t2_data", o.data, 32'h3C);

    // Both requesters with LDI at once.
    p1 = acc_cnt[1];
    q0.push_back({2'b01, 2'd2, 2'd2, 8'h11});
    q1.push_back({2'b01, 2'd2, 2'd2, 8'h22});
    wait_acc(1, p1, 30);
    repeat (4) @(posedge clock);
    a0 = acc_cyc[0]; a1 = acc_cyc[1];
    chk("t3_gap", a1 - a0, 32'd3);
    o = get_obs(a0);     chk("t3_rdy1_low", o.rdy1, 32'h0);
    o = get_obs(a0 + 2); chk("t3_id0", o.id, 32'h0); chk("t3_data0", o.data, 32'h11);
    o = get_obs(a1 + 2); chk("t3_id1", o.id, 32'h1); chk("t3_data1", o.data, 32'h22);

    // Reserved op.
    p0 = acc_cnt[0];
    q0.push_back({2'b11, 2'd0, 2'd1, 8'h00});
    wait_acc(0, p0, 20);
    repeat (4) @(posedge clock);
    a = acc_cyc[0];
    o = get_obs(a);     chk("t4_ready0", o.rdy0, 32'h1);
    o = get_obs(a + 1); chk("t4_done", o.done, 32'h1); chk("t4_err", o.err, 32'h1);
    chk("t4_no_strobe", {o.rd, o.wr}, 32'h0);

    // RD R0 while requester 1 waits.
    p0 = acc_cnt[0]; p1 = acc_cnt[1];
    q0.push_back({2'b10, 2'd0, 2'd0, 8'h00});
    wait_acc(0, p0, 20);
    q1.push_back({2'b01, 2'd0, 2'd3, 8'h77});
    wait_acc(1, p1, 20);
    repeat (4) @(posedge clock);
    a = acc_cyc[0];
    for (int i = 1; i <= 3; i++) begin
      o = get_obs(a + i); chk("t6_rdy1_held", o.rdy1, 32'h0);
    end
    chk("t6_req1_after", acc_cyc[1] - a, 32'd4);
    o = get_obs(a + 3); chk("t6_done", o.done, 32'h1); chk("t6_data", o.data, 32'hFF);

    // Reset during WAIT of a MOV issued by requester 0.
    p0 = acc_cnt[0];
    q0.push_back({2'b00, 2'd1, 2'd0, 8'h00});
    wait_acc(0, p0, 20);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("t5_read_en",  read_en,  32'h0);
    chk("t5_write_en", write_en, 32'h0);
    chk("t5_data_bus", data_bus, 32'h0);
    chk("t5_done",     done,     32'h0);
    chk("t5_rsp_id",   rsp_id,   32'h0);
    chk("t5_rsp_data", rsp_data, 32'h0);
    chk("t5_rsp_err",  rsp_err,  32'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    p1 = acc_cnt[1];
    q0.push_back({2'b01, 2'd1, 2'd1, 8'h5A});
    q1.push_back({2'b01, 2'd2, 2'd2, 8'h66});
    wait_acc(1, p1, 30);
    repeat (4) @(posedge clock);
    a0 = acc_cyc[0]; a1 = acc_cyc[1];
    o = get_obs(a0); chk("t5_req0_wins", o.rdy0, 32'h1); chk("t5_req1_waits", o.rdy1, 32'h0);
    chk("t5_order", a1 - a0, 32'd3);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      c.op  = 2'($urandom_range(0, 3));
      c.src = 2'($urandom_range(0, 3));
      c.dst = 2'($urandom_range(0, 3));
      c.imm = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) q0.push_back(c);
      else                           q1.push_back(c);
      n = $urandom_range(0, 4);
      repeat (n) @(posedge clock);
      while (q0.size() > 2 || q1.size() > 2) @(posedge clock);
    end

    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || r0_if.valid || r1_if.valid || cyc < free_at)
           && n < 4000) begin
      @(posedge clock);
      n++;
    end
    if (n >= 4000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout q0=%0d q1=%0d", q0.size(), q1.size());
    end
    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
